// File: rtl/harvard_ctrl_pkg.sv
// Shared types and constants for the Harvard-core issue controller.
// Optional multiplier flow is enabled by defining ALU_MUL_EN.
package harvard_ctrl_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned DM_AW    = 8;
  localparam int unsigned OPC_W    = 6;

  localparam logic [OPC_W-1:0] OP_LI   = 6'd0;
  localparam logic [OPC_W-1:0] OP_MOV  = 6'd1;
  localparam logic [OPC_W-1:0] OP_LD   = 6'd2;
  localparam logic [OPC_W-1:0] OP_ST   = 6'd3;
  localparam logic [OPC_W-1:0] OP_ADD  = 6'd4;
  localparam logic [OPC_W-1:0] OP_SUB  = 6'd5;
  localparam logic [OPC_W-1:0] OP_NEG  = 6'd6;
  localparam logic [OPC_W-1:0] OP_MUL  = 6'd7;
  localparam logic [OPC_W-1:0] OP_AND  = 6'd8;
  localparam logic [OPC_W-1:0] OP_OR   = 6'd9;
  localparam logic [OPC_W-1:0] OP_XOR  = 6'd10;
  localparam logic [OPC_W-1:0] OP_NOT  = 6'd11;
  localparam logic [OPC_W-1:0] OP_NAND = 6'd12;
  localparam logic [OPC_W-1:0] OP_NOR  = 6'd13;
  localparam logic [OPC_W-1:0] OP_SHL  = 6'd14;
  localparam logic [OPC_W-1:0] OP_SRA  = 6'd15;
  localparam logic [OPC_W-1:0] OP_SHR  = 6'd16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_ERR
`ifdef ALU_MUL_EN
    ,
    ST_MUL_WAIT,
    ST_WB_HI
`endif
  } state_t;

  typedef enum logic [2:0] {
    CL_LI,
    CL_MOV,
    CL_LD,
    CL_ST,
    CL_ALU,
    CL_MUL,
    CL_ILL
  } iclass_t;

  typedef struct packed {
    iclass_t             cls;
    logic [ALU_OP_W-1:0] alu_op;
    logic                illegal;
    logic [REG_AW-1:0]   rdst2;
    logic [REG_AW-1:0]   rdst1;
    logic [REG_AW-1:0]   rsrc2;
    logic [REG_AW-1:0]   rsrc1;
    logic [DATA_W-1:0]   imm;
    logic [DM_AW-1:0]    ld_addr;
    logic [DM_AW-1:0]    st_addr;
  } dec_t;

endpackage

// File: rtl/alu_issue_ctrl_issue_decode.sv
// Combinational opcode classification and field extraction.
// Opcode 000111 is a multiply only when ALU_MUL_EN is defined.
module issue_decode
  import harvard_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [OPC_W-1:0] op;

  assign op = instr_i[31:26];

  always_comb begin
    dec_o         = '0;
    dec_o.rdst2   = instr_i[25:21];
    dec_o.rdst1   = instr_i[20:16];
    dec_o.rsrc2   = instr_i[9:5];
    dec_o.rsrc1   = instr_i[4:0];
    dec_o.imm     = instr_i[15:0];
    dec_o.ld_addr = instr_i[7:0];
    dec_o.st_addr = instr_i[25:18];
    // Low nibble minus 4 equals (opcode - 4) for every ALU opcode 4..16.
    dec_o.alu_op  = instr_i[29:26] - 4'd4;
    if (op == OP_LI) begin
      dec_o.cls = CL_LI;
    end else if (op == OP_MOV) begin
      dec_o.cls = CL_MOV;
    end else if (op == OP_LD) begin
      dec_o.cls = CL_LD;
    end else if (op == OP_ST) begin
      dec_o.cls = CL_ST;
    end else if (op == OP_MUL) begin
`ifdef ALU_MUL_EN
      dec_o.cls = CL_MUL;
`else
      dec_o.cls = CL_ILL;
`endif
    end else if (op >= OP_ADD && op <= OP_SHR) begin
      dec_o.cls = CL_ALU;
    end else begin
      dec_o.cls = CL_ILL;
    end
    dec_o.illegal = (dec_o.cls == CL_ILL);
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller: sequences regfile, ALU, multiplier and data memory.
// Define ALU_MUL_EN to enable the MUL / MUL_WAIT / WB_HI flow.
module alu_issue_ctrl
  import harvard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_TIMEOUT = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [31:0]         instr,
  output logic [REG_AW-1:0]   rf_ra1,
  output logic [REG_AW-1:0]   rf_ra2,
  input  logic [DATA_W-1:0]   rf_rd1,
  input  logic [DATA_W-1:0]   rf_rd2,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_wa,
  output logic [DATA_W-1:0]   rf_wd,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [DATA_W-1:0]   alu_y,
  output logic                mul_start,
  input  logic                mul_done,
  input  logic [31:0]         mul_p,
  output logic                dm_re,
  output logic                dm_we,
  output logic [DM_AW-1:0]    dm_addr,
  output logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W-1:0]   dm_rdata,
  output logic                busy,
  output logic                err
);

  state_t              state_q;
  logic [31:0]         instr_q;
  logic [DATA_W-1:0]   op1_q;
  logic [DATA_W-1:0]   op2_q;
  logic [REG_AW-1:0]   rf_ra1_q;
  logic [REG_AW-1:0]   rf_ra2_q;
  logic                rf_we_q;
  logic [REG_AW-1:0]   rf_wa_q;
  logic [DATA_W-1:0]   rf_wd_q;
  logic [ALU_OP_W-1:0] alu_op_q;
  logic                mul_start_q;
  logic                dm_re_q;
  logic                dm_we_q;
  logic [DM_AW-1:0]    dm_addr_q;
  logic [DATA_W-1:0]   dm_wdata_q;
  logic                err_q;
  logic [31:0]         dec_instr;
  dec_t                dec;

`ifdef ALU_MUL_EN
  localparam int unsigned CNT_W = $clog2(MUL_TIMEOUT + 1);
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] mul_hi_q;
`else
  logic unused_mul;
  assign unused_mul = ^{mul_done, mul_p, (MUL_TIMEOUT != 0)};
`endif

  // The live word is decoded only while IDLE; afterwards the latched copy drives every field.
  assign dec_instr = (state_q == ST_IDLE) ? instr : instr_q;

  issue_decode u_decode (
    .instr_i (dec_instr),
    .dec_o   (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      rf_ra1_q    <= '0;
      rf_ra2_q    <= '0;
      rf_we_q     <= 1'b0;
      rf_wa_q     <= '0;
      rf_wd_q     <= '0;
      alu_op_q    <= '0;
      mul_start_q <= 1'b0;
      dm_re_q     <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= '0;
      err_q       <= 1'b0;
`ifdef ALU_MUL_EN
      cnt_q       <= '0;
      mul_hi_q    <= '0;
`endif
    end else begin
      rf_ra1_q    <= '0;
      rf_ra2_q    <= '0;
      rf_we_q     <= 1'b0;
      rf_wa_q     <= '0;
      rf_wd_q     <= '0;
      alu_op_q    <= '0;
      mul_start_q <= 1'b0;
      dm_re_q     <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= '0;
      err_q       <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            unique case (dec.cls)
              CL_LI: begin
                state_q <= ST_WB;
                rf_we_q <= 1'b1;
                rf_wa_q <= dec.rdst2;
                rf_wd_q <= dec.imm;
              end
              CL_LD: begin
                state_q   <= ST_MEM;
                dm_re_q   <= 1'b1;
                dm_addr_q <= dec.ld_addr;
              end
              CL_ILL: begin
                state_q <= ST_ERR;
                err_q   <= 1'b1;
              end
              default: begin
                state_q  <= ST_READ;
                rf_ra1_q <= dec.rsrc1;
                rf_ra2_q <= dec.rsrc2;
              end
            endcase
          end
        end
        ST_READ: begin
          op1_q <= rf_rd1;
          op2_q <= rf_rd2;
          unique case (dec.cls)
            CL_MOV: begin
              state_q <= ST_WB;
              rf_we_q <= 1'b1;
              rf_wa_q <= dec.rdst2;
              rf_wd_q <= rf_rd1;
            end
            CL_ST: begin
              state_q    <= ST_MEM;
              dm_we_q    <= 1'b1;
              dm_addr_q  <= dec.st_addr;
              dm_wdata_q <= rf_rd1;
            end
            default: begin
              state_q     <= ST_EXEC;
              alu_op_q    <= dec.alu_op;
              mul_start_q <= (dec.cls == CL_MUL);
            end
          endcase
        end
        ST_EXEC: begin
`ifdef ALU_MUL_EN
          if (dec.cls == CL_MUL) begin
            state_q <= ST_MUL_WAIT;
            cnt_q   <= '0;
          end else begin
`endif
            state_q <= ST_WB;
            rf_we_q <= 1'b1;
            rf_wa_q <= dec.rdst1;
            rf_wd_q <= alu_y;
`ifdef ALU_MUL_EN
          end
`endif
        end
`ifdef ALU_MUL_EN
        ST_MUL_WAIT: begin
          // A product arriving on the timeout edge takes priority over the error.
          if (mul_done) begin
            state_q  <= ST_WB;
            mul_hi_q <= mul_p[31:16];
            rf_we_q  <= 1'b1;
            rf_wa_q  <= dec.rdst1;
            rf_wd_q  <= mul_p[15:0];
          end else if (cnt_q == CNT_W'(MUL_TIMEOUT - 1)) begin
            state_q <= ST_ERR;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WB_HI: begin
          state_q <= ST_IDLE;
        end
`endif
        ST_MEM: begin
          if (dec.cls == CL_LD) begin
            state_q <= ST_WB;
            rf_we_q <= 1'b1;
            rf_wa_q <= dec.rdst2;
            rf_wd_q <= dm_rdata;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WB: begin
`ifdef ALU_MUL_EN
          if (dec.cls == CL_MUL) begin
            state_q <= ST_WB_HI;
            rf_we_q <= 1'b1;
            rf_wa_q <= dec.rdst2;
            rf_wd_q <= mul_hi_q;
          end else begin
            state_q <= ST_IDLE;
          end
`else
          state_q <= ST_IDLE;
`endif
        end
        ST_ERR: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign rf_ra1      = rf_ra1_q;
  assign rf_ra2      = rf_ra2_q;
  assign rf_we       = rf_we_q;
  assign rf_wa       = rf_wa_q;
  assign rf_wd       = rf_wd_q;
  assign alu_op      = alu_op_q;
  assign alu_a       = (state_q == ST_EXEC) ? op2_q : '0;
  assign alu_b       = (state_q == ST_EXEC) ? op1_q : '0;
  assign mul_start   = mul_start_q;
  assign dm_re       = dm_re_q;
  assign dm_we       = dm_we_q;
  assign dm_addr     = dm_addr_q;
  assign dm_wdata    = dm_wdata_q;
  assign err         = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl; covers both ALU_MUL_EN builds.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rf_ra1, rf_ra2, rf_wa;
  logic [15:0] rf_rd1, rf_rd2, rf_wd;
  logic        rf_we;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_y;
  logic        mul_start, mul_done;
  logic [31:0] mul_p;
  logic        dm_re, dm_we;
  logic [7:0]  dm_addr;
  logic [15:0] dm_wdata, dm_rdata;
  logic        busy, err;

  int checks   = 0;
  int failures = 0;

  alu_issue_ctrl #(.MUL_TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_ra1      (rf_ra1),
    .rf_ra2      (rf_ra2),
    .rf_rd1      (rf_rd1),
    .rf_rd2      (rf_rd2),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_y       (alu_y),
    .mul_start   (mul_start),
    .mul_done    (mul_done),
    .mul_p       (mul_p),
    .dm_re       (dm_re),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [31:0] w);
    instr_valid = 1'b1;
    instr       = w;
    tick();
    instr_valid = 1'b0;
    instr       = 32'hFFFF_FFFF;
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    rf_rd1 = '0; rf_rd2 = '0; alu_y = '0; mul_done = 1'b0; mul_p = '0; dm_rdata = '0;
    tick(); tick();
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_we", {rf_we, mul_start, dm_re, dm_we}, 0);
    chk("rst_addr", {rf_ra1, rf_ra2, rf_wa, dm_addr}, 0);
    chk("rst_data", {rf_wd, dm_wdata}, 0);
    chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
    rst_n = 1'b1;
    tick();

    // LI R3=0x1234; fetch keeps offering LI R4=0x5555 while busy
    instr_valid = 1'b1; instr = 32'h0060_1234;
    tick();
    instr = 32'h0080_5555;
    chk("li_we", rf_we, 1);
    chk("li_wa", rf_wa, 3);
    chk("li_wd", rf_wd, 16'h1234);
    chk("li_busy_ready", {busy, instr_ready}, 2'b10);
    tick();
    chk("li_gap_we", rf_we, 0);
    chk("li_ready_back", instr_ready, 1);
    tick();
    instr_valid = 1'b0;
    chk("li2_we", rf_we, 1);
    chk("li2_wa", rf_wa, 4);
    chk("li2_wd", rf_wd, 16'h5555);
    tick();

    // ADD R5 <- R1(3) + R2(4)
    accept(32'h1005_0022);
    chk("add_read_ra1", rf_ra1, 2);
    chk("add_read_ra2", rf_ra2, 1);
    chk("add_read_we", rf_we, 0);
    rf_rd1 = 16'h0004; rf_rd2 = 16'h0003;
    tick();
    rf_rd1 = '0; rf_rd2 = '0; alu_y = 16'h0007;
    chk("add_aluop", alu_op, 0);
    chk("add_a", alu_a, 16'h0003);
    chk("add_b", alu_b, 16'h0004);
    chk("add_mulstart", mul_start, 0);
    tick();
    alu_y = '0;
    chk("add_we", rf_we, 1);
    chk("add_wa", rf_wa, 5);
    chk("add_wd", rf_wd, 16'h0007);
    tick();
    chk("add_done", {rf_we, instr_ready}, 2'b01);

    // ST DM[0x2A] <- R7(0xBEEF)
    accept(32'h0CA8_0007);
    chk("st_ra1", rf_ra1, 7);
    rf_rd1 = 16'hBEEF;
    tick();
    rf_rd1 = '0;
    chk("st_dmwe", dm_we, 1);
    chk("st_addr", dm_addr, 8'h2A);
    chk("st_wdata", dm_wdata, 16'hBEEF);
    chk("st_no_rfwe", rf_we, 0);
    tick();
    chk("st_done", {dm_we, instr_ready}, 2'b01);

    // LD R6 <- DM[0x2A]
    accept(32'h08C0_002A);
    chk("ld_dmre", dm_re, 1);
    chk("ld_addr", dm_addr, 8'h2A);
    dm_rdata = 16'hBEEF;
    tick();
    dm_rdata = '0;
    chk("ld_we", rf_we, 1);
    chk("ld_wa", rf_wa, 6);
    chk("ld_wd", rf_wd, 16'hBEEF);
    tick();
    chk("ld_done", instr_ready, 1);

`ifdef ALU_MUL_EN
    // MUL {R9,R8} <- 0x0001_FFFE, product on third wait cycle
    accept(32'h1D28_0000);
    tick();
    chk("mul_start", mul_start, 1);
    chk("mul_aluop", alu_op, 3);
    tick();
    chk("mul_w1", {mul_start, rf_we, err}, 0);
    tick(); tick();
    mul_done = 1'b1; mul_p = 32'h0001_FFFE;
    tick();
    mul_done = 1'b0; mul_p = '0;
    chk("mul_lo_we", rf_we, 1);
    chk("mul_lo_wa", rf_wa, 8);
    chk("mul_lo_wd", rf_wd, 16'hFFFE);
    tick();
    chk("mul_hi_we", rf_we, 1);
    chk("mul_hi_wa", rf_wa, 9);
    chk("mul_hi_wd", rf_wd, 16'h0001);
    tick();
    chk("mul_done", {rf_we, instr_ready}, 2'b01);

    // Timeout after 4 wait cycles
    accept(32'h1D28_0000);
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mto_wait", {err, rf_we}, 0);
    end
    tick();
    chk("mto_err", err, 1);
    chk("mto_no_we", rf_we, 0);
    tick();
    chk("mto_idle", {err, instr_ready, rf_we}, 3'b010);

    // Product on the timeout edge is honoured
    accept(32'h1D28_0000);
    tick(); tick();
    tick(); tick(); tick();
    mul_done = 1'b1; mul_p = 32'h1234_5678;
    tick();
    mul_done = 1'b0; mul_p = '0;
    chk("mlate_noerr", err, 0);
    chk("mlate_we", rf_we, 1);
    chk("mlate_wd", rf_wd, 16'h5678);
    tick();
    chk("mlate_hi", rf_wd, 16'h1234);
    tick();
`else
    // Opcode 000111 is illegal without the multiplier
    accept(32'h1D28_0000);
    chk("mulill_err", err, 1);
    chk("mulill_nowe", {rf_we, mul_start}, 0);
    tick();
    chk("mulill_idle", {err, instr_ready}, 2'b01);
`endif

    // Illegal opcode 0x3F
    accept(32'hFC00_0000);
    chk("ill_err", err, 1);
    chk("ill_nowrite", {rf_we, dm_we}, 0);
    tick();
    chk("ill_pulse", {err, instr_ready}, 2'b01);

    // Reset during EXEC of an ADD
    accept(32'h1005_0022);
    rf_rd1 = 16'h0004; rf_rd2 = 16'h0003;
    tick();
    chk("rx_in_exec", alu_op, 0);
    rst_n = 1'b0;
    #1;
    chk("rx_ready_async", instr_ready, 1);
    chk("rx_alu_a", alu_a, 0);
    tick();
    chk("rx_we_held", rf_we, 0);
    rst_n = 1'b1;
    tick();
    chk("rx_we_after", rf_we, 0);
    chk("rx_ready_after", instr_ready, 1);
    tick();
    chk("rx_we_later", rf_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
